// File: rtl/chacha20_inv_quarter_round.sv
// Inverse ChaCha20 quarter-round. A four-stage valid/ready pipeline that
// recovers the pre-round (a,b,c,d) tuple from a post-round tuple.
module chacha20_inv_quarter_round #(
   parameter int DATA_WIDTH = 32,
   parameter int ROT1       = 16,
   parameter int ROT2       = 12,
   parameter int ROT3       = 8,
   parameter int ROT4       = 7
) (
   input  logic                  i_aclk,
   input  logic                  i_aresetn,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic [DATA_WIDTH-1:0] i_c,
   input  logic [DATA_WIDTH-1:0] i_d,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_a,
   output logic [DATA_WIDTH-1:0] o_b,
   output logic [DATA_WIDTH-1:0] o_c,
   output logic [DATA_WIDTH-1:0] o_d
);

   if (DATA_WIDTH != 32) begin : g_width_check
      $error("chacha20_inv_quarter_round: only DATA_WIDTH = 32 is supported");
   end

   typedef struct packed {
      logic                  v;
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [DATA_WIDTH-1:0] c;
      logic [DATA_WIDTH-1:0] d;
   } stage_t;

   function automatic logic [DATA_WIDTH-1:0] ror(input logic [DATA_WIDTH-1:0] x,
                                                 input int unsigned n);
      return (x >> n) | (x << (DATA_WIDTH - n));
   endfunction

   stage_t s1_q, s2_q, s3_q, s4_q;
   stage_t s1_d, s2_d, s3_d, s4_d;
   logic   advance;

   // The whole pipe moves in lock-step, so bubbles are preserved.
   assign advance = ~s4_q.v | i_ready;
   assign o_ready = advance;

   // Each stage undoes one forward step, last forward step first.
   always_comb begin
      s1_d   = '{v: i_valid, a: i_a, b: i_b, c: i_c, d: i_d};
      s1_d.b = ror(i_b, ROT4) ^ i_c;
      s1_d.c = i_c - i_d;

      s2_d   = s1_q;
      s2_d.d = ror(s1_q.d, ROT3) ^ s1_q.a;
      s2_d.a = s1_q.a - s1_q.b;

      s3_d   = s2_q;
      s3_d.b = ror(s2_q.b, ROT2) ^ s2_q.c;
      s3_d.c = s2_q.c - s2_q.d;

      s4_d   = s3_q;
      s4_d.d = ror(s3_q.d, ROT1) ^ s3_q.a;
      s4_d.a = s3_q.a - s3_q.b;
   end

   // NOTE: data registers are reset along with the valid bits so the outputs
   // read zero during reset; invalid stages otherwise load whatever arrives.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
         s4_q <= '0;
      end else if (advance) begin
         // NOTE: non-blocking so every stage samples its predecessor's old value.
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
         s4_q <= s4_d;
      end
   end

   assign o_valid = s4_q.v;
   assign o_a     = s4_q.a;
   assign o_b     = s4_q.b;
   assign o_c     = s4_q.c;
   assign o_d     = s4_q.d;

endmodule

// File: tb/tb_chacha20_inv_quarter_round.sv
// Self-checking bench for chacha20_inv_quarter_round: a forward quarter-round
// model produces post-round stimulus and a scoreboard expects the pre-round tuple.
module tb_chacha20_inv_quarter_round;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
   } tuple_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b1;
   logic [31:0] i_a = '0, i_b = '0, i_c = '0, i_d = '0;
   logic        o_ready, o_valid;
   logic [31:0] o_a, o_b, o_c, o_d;

   int     chk_cnt = 0;
   int     pass_cnt = 0;
   tuple_t exp_q[$];
   tuple_t cur_pre = '0;

   always #5 clk = ~clk;

   chacha20_inv_quarter_round dut (
      .i_aclk   (clk),
      .i_aresetn(rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_a      (i_a),
      .i_b      (i_b),
      .i_c      (i_c),
      .i_d      (i_d),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_a      (o_a),
      .o_b      (o_b),
      .o_c      (o_c),
      .o_d      (o_d)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Forward quarter-round exactly as RFC 7539 writes it.
   function automatic tuple_t fwd_qr(input tuple_t t);
      tuple_t r = t;
      r.a = r.a + r.b; r.d = rol(r.d ^ r.a, 16);
      r.c = r.c + r.d; r.b = rol(r.b ^ r.c, 12);
      r.a = r.a + r.b; r.d = rol(r.d ^ r.a, 8);
      r.c = r.c + r.d; r.b = rol(r.b ^ r.c, 7);
      return r;
   endfunction

   function automatic tuple_t rand_tuple();
      tuple_t t;
      t.a = $urandom; t.b = $urandom; t.c = $urandom; t.d = $urandom;
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pre(input tuple_t pre);
      tuple_t post = fwd_qr(pre);
      cur_pre = pre;
      i_a = post.a; i_b = post.b; i_c = post.c; i_d = post.d;
      i_valid = 1'b1;
   endtask

   task automatic drive_post(input tuple_t post, input tuple_t pre);
      cur_pre = pre;
      i_a = post.a; i_b = post.b; i_c = post.c; i_d = post.d;
      i_valid = 1'b1;
   endtask

   // Drive vpat[j] as i_valid on cycle j and expect the same o_valid pattern 4 cycles later.
   task automatic run_pattern(input string name, input logic [15:0] vpat, input int n);
      if (vpat[0]) drive_pre(rand_tuple()); else i_valid = 1'b0;
      for (int j = 1; j <= n + 4; j++) begin
         step();
         if (j >= 4) check(name, {127'd0, o_valid}, {127'd0, vpat[j-4]});
         else        check(name, {127'd0, o_valid}, 128'd0);
         if (j < n && vpat[j]) drive_pre(rand_tuple());
         else i_valid = 1'b0;
      end
   endtask

   // Scoreboard: pop on every transfer, push on every accept.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", {1'b1, 127'd0}, 128'd0);
            else check("sb_data", {o_a, o_b, o_c, o_d}, exp_q.pop_front());
         end
         if (i_valid && o_ready) exp_q.push_back(cur_pre);
      end
   end

   localparam tuple_t RFC_PRE  = '{32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
   localparam tuple_t RFC_POST = '{32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};

   task automatic rfc_run(input string name);
      drive_post(RFC_POST, RFC_PRE);
      for (int j = 1; j <= 4; j++) begin
         step();
         i_valid = 1'b0;
         if (j < 4) check({name, "_lat"}, {127'd0, o_valid}, 128'd0);
      end
      check({name, "_valid"}, {127'd0, o_valid}, 128'd1);
      check({name, "_data"}, {o_a, o_b, o_c, o_d}, RFC_PRE);
   endtask

   initial begin
      tuple_t hold;
      tuple_t zero = '0;

      // Pin the model against the RFC vector and the zero vector.
      check("model_rfc", fwd_qr(RFC_PRE), RFC_POST);
      check("model_zero", fwd_qr(zero), 128'd0);

      #2;
      check("reset_outputs", {o_valid, o_a, o_b, o_c, o_d}, 129'd0);
      check("reset_ready", {127'd0, o_ready}, 128'd1);
      #10 rst_n = 1'b1;
      step();

      rfc_run("rfc");

      drive_post('0, '0);
      for (int j = 1; j <= 4; j++) begin
         step();
         i_valid = 1'b0;
      end
      check("zero_valid", {127'd0, o_valid}, 128'd1);
      check("zero_data", {o_a, o_b, o_c, o_d}, 128'd0);
      step();

      // Throughput: 8 back-to-back tuples, o_valid high 8 consecutive cycles.
      run_pattern("throughput", 16'h00ff, 8);
      // Bubbles: alternating valid pattern preserved.
      run_pattern("bubbles", 16'h0155, 9);
      check("after_patterns_empty", exp_q.size(), 128'd0);

      // Backpressure: fill the pipe, stall for 5 cycles, then drain.
      drive_pre('{32'h00000001, 32'hfffffff0, 32'h80000000, 32'h7fffffff});
      for (int k = 1; k <= 4; k++) begin
         step();
         drive_pre(rand_tuple());
      end
      i_ready = 1'b0;
      #1;
      check("stall_valid", {127'd0, o_valid}, 128'd1);
      hold = '{o_a, o_b, o_c, o_d};
      for (int k = 0; k < 5; k++) begin
         check("stall_ready", {127'd0, o_ready}, 128'd0);
         check("stall_hold", {o_valid, o_a, o_b, o_c, o_d}, {1'b1, hold});
         step();
         drive_pre(rand_tuple());
      end
      i_ready = 1'b1;
      i_valid = 1'b0;
      for (int k = 0; k < 8; k++) step();
      check("drain_empty", exp_q.size(), 128'd0);

      // Mid-stream reset with 3 tuples in flight.
      for (int k = 0; k < 3; k++) begin
         drive_pre(rand_tuple());
         step();
      end
      i_valid = 1'b0;
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midreset_outputs", {o_valid, o_a, o_b, o_c, o_d}, 129'd0);
      check("midreset_ready", {127'd0, o_ready}, 128'd1);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      rfc_run("rfc_after_reset");
      for (int k = 0; k < 6; k++) begin
         step();
         check("no_stale", {127'd0, o_valid}, 128'd0);
      end
      check("final_empty", exp_q.size(), 128'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/chacha20_inv_quarter_round.md
Name: chacha20_inv_quarter_round

Overview:
Pipelined inverse of the ChaCha20 quarter-round. It takes a post-quarter-round word tuple (a,b,c,d) and recovers the pre-round tuple. It uses modular subtraction (the counterpart of the registered adder) plus right-rotations and XOR. It sits beside the forward round core and is used for known-answer self-checks and state rollback in the chacha20 datapath. The block has a 4-stage valid/ready pipeline with throughput of one tuple per cycle.

Parameters:
DATA_WIDTH, 32, word width. Only 32 is supported; any other value is a configuration error.
ROT1, 16, rotation of forward step 1 (undone last).
ROT2, 12, rotation of forward step 2.
ROT3, 8, rotation of forward step 3.
ROT4, 7, rotation of forward step 4 (undone first).

Ports:
i_aclk  in  1  clock, rising edge.
i_aresetn  in  1  asynchronous active-low reset.
i_valid  in  1  input tuple valid.
o_ready  out  1  block accepts the input tuple this cycle.
i_a, i_b, i_c, i_d  in  DATA_WIDTH each  post-round words.
o_valid  out  1  output tuple valid.
i_ready  in  1  downstream accepts the output tuple.
o_a, o_b, o_c, o_d  out  DATA_WIDTH each  recovered pre-round words.

Behaviour:
- One clock. Reset is asynchronous and active-low (i_aresetn, i_aclk).
- Pipeline structure:
  - Four stages S1..S4.
  - Each stage has a valid bit and four DATA_WIDTH data registers.
  - S4 drives o_valid and o_a..o_d directly; there is no combinational path from i_a..i_d to the outputs.
- Per-stage operation. ror is rotate-right. All arithmetic is mod 2^32, with wrap on underflow.
  - S1 (undo step 4): b' = ror(b,ROT4) ^ c; c' = c − d; a and d pass through.
  - S2 (undo step 3): d' = ror(d,ROT3) ^ a; a' = a − b'; where b' is the S1 result. b and c pass through.
  - S3 (undo step 2): b' = ror(b,ROT2) ^ c; c' = c − d. a and d pass through.
  - S4 (undo step 1): d' = ror(d,ROT1) ^ a; a' = a − b'. b and c pass through.
- Advance and handshake:
  - advance = ~o_valid | i_ready.
  - When advance = 1, all stages shift together: S1 loads from the inputs, and S1.valid <= i_valid.
  - When advance = 0, all stage registers hold.
  - o_ready = advance (combinational from o_valid and i_ready only, independent of i_valid).
  - Input is accepted on i_valid & o_ready.
  - Output is transferred on o_valid & i_ready.
- Bubbles do not collapse, because the pipeline advances as a whole.
- Latency: exactly 4 accepted-advance cycles. A tuple accepted at edge N appears at o_valid after edge N+3 when there are no stalls.
- Output stability: while o_valid=1 and i_ready=0, o_a..o_d and o_valid hold stable. Input data is ignored during the stall.
- Data registers of invalid stages still load and may carry garbage. Only the valid bits are qualifying.
- Reset, including mid-operation:
  - All valid bits and all data registers clear to 0 immediately, so o_valid=0 and o_a..o_d=0.
  - o_ready reads 1 while in reset.
  - In-flight tuples are discarded.
  - The first accept happens on the first rising edge after deassertion.
- No internal state beyond the pipeline registers; there are no counters or mode bits.

Test Plan:
- RFC 7539 §2.1.1 known answer. Input a=ea2a92f4, b=cb1cf8ce, c=4581472e, d=5881c4bb with i_ready=1 -> after 4 cycles, o_valid=1 with a=11111111, b=01020304, c=9b8d6f43, d=01234567.
- Zero vector. Input all 00000000 -> output all 00000000, latency 4.
- Throughput and ordering. Drive 8 back-to-back tuples (random, generated by a forward-QR model) with i_ready=1 -> o_valid high for 8 consecutive cycles. Outputs match the model's pre-round inputs in order, including cases with a<b (subtraction wrap).
- Backpressure. With the pipe full, hold i_ready=0 for 5 cycles -> o_ready=0, outputs stable, no loss or duplication. Release -> remaining tuples emerge in order, one per cycle.
- Bubbles. Alternate i_valid 1/0 -> o_valid pattern 1/0 is preserved with a 4-cycle delay.
- Mid-stream reset. Assert i_aresetn=0 asynchronously (between edges) with 3 tuples in flight -> o_valid=0 and outputs=0 immediately. After release, the RFC vector run alone gives the correct result with no stale outputs.
